// File: rtl/amp_pwr_seq.sv
// amp_pwr_seq -- power-up, configuration and fault-recovery sequencer for the
// Merus amplifier interface. It drives the amp enable and mute pins, re-arms
// and triggers amp_i2c_master, and watches I2S lock and the amp fault pin.
//
// Ports (clk_in domain):
//   clk_in       in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   level: audio path up (1) / down (0)
//   i2s_lock     in   I2S framing valid
//   amp_fault_n  in   amp fault pin, active low, already synchronised
//   amp_en       out  amp enable (1 = powered)
//   amp_mute     out  amp mute (1 = muted)
//   i2c_resetb   out  active-low reset to amp_i2c_master
//   send_cfg     out  config trigger to amp_i2c_master
//   ready        out  high only in RUN
//   fail         out  high only in FAILED
//   retry_cnt    out  fault retries consumed since the last IDLE
//
// Build option: define AMP_SEQ_FAULT_RETRY_EN to let FAULT retry the power-up
// up to MAX_RETRY times. Without it FAULT always ends in FAILED and retry_cnt
// is tied to 0.
module amp_pwr_seq #(
  parameter int unsigned EN_DLY     = 1024,
  parameter int unsigned CFG_PULSE  = 16,
  parameter int unsigned CFG_WAIT   = 4096,
  parameter int unsigned UNMUTE_DLY = 256,
  parameter int unsigned FAULT_FILT = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic       i2s_lock,
  input  logic       amp_fault_n,
  output logic       amp_en,
  output logic       amp_mute,
  output logic       i2c_resetb,
  output logic       send_cfg,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_POWER_UP, S_CONFIG, S_WAIT_LOCK, S_UNMUTE,
    S_RUN, S_FAULT, S_FAILED, S_SHUTDOWN
  } state_t;

  // Counter load values: a timed state of N cycles loads N-1 and exits at 0.
  localparam logic [15:0] EN_LD     = 16'(EN_DLY - 1);
  localparam logic [15:0] CFG_LD    = 16'(CFG_WAIT - 1);
  localparam logic [15:0] UNM_LD    = 16'(UNMUTE_DLY - 1);
  localparam logic [15:0] FILT_LAST = 16'(FAULT_FILT - 1);
  // send_cfg is high while the CONFIG counter is still at or above this value,
  // i.e. for the first CFG_PULSE cycles of the state.
  localparam int unsigned PULSE_THR_I = (CFG_PULSE >= CFG_WAIT) ? 0 : CFG_WAIT - CFG_PULSE;
  localparam logic [15:0] PULSE_THR   = 16'(PULSE_THR_I);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] filt_q, filt_d;
  logic        amp_en_q, amp_en_d;
  logic        amp_mute_q, amp_mute_d;
  logic        i2c_resetb_q, i2c_resetb_d;
  logic        send_cfg_q, send_cfg_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        active, fault_hit, timer_done;

`ifdef AMP_SEQ_FAULT_RETRY_EN
  logic [3:0] retry_q, retry_d;
`endif

  // Next-state logic. Priority: fault > start drop > lock loss > timer.
  always_comb begin
    state_d    = state_q;
    active     = state_q inside {S_POWER_UP, S_CONFIG, S_WAIT_LOCK, S_UNMUTE, S_RUN};
    timer_done = (cnt_q == 16'd0);
    fault_hit  = active && !amp_fault_n && (filt_q == FILT_LAST);
    if (fault_hit) begin
      state_d = S_FAULT;
    end else if (active && !start) begin
      state_d = S_SHUTDOWN;
    end else begin
      unique case (state_q)
        S_IDLE:      if (start) state_d = S_POWER_UP;
        S_POWER_UP:  if (timer_done) state_d = S_CONFIG;
        S_CONFIG:    if (timer_done) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: if (i2s_lock) state_d = S_UNMUTE;
        S_UNMUTE: begin
          if (!i2s_lock)       state_d = S_WAIT_LOCK;
          else if (timer_done) state_d = S_RUN;
        end
        S_RUN:       if (!i2s_lock) state_d = S_WAIT_LOCK;
        S_FAULT: begin
          if (timer_done) begin
`ifdef AMP_SEQ_FAULT_RETRY_EN
            if (retry_q < 4'(MAX_RETRY)) state_d = S_POWER_UP;
            else                         state_d = S_FAILED;
`else
            state_d = S_FAILED;
`endif
          end
        end
        S_FAILED:    if (!start) state_d = S_IDLE;
        S_SHUTDOWN:  if (timer_done) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Shared down-counter, reloaded on every state entry (including the
  // UNMUTE -> WAIT_LOCK -> UNMUTE bounce).
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        S_POWER_UP, S_FAULT, S_SHUTDOWN: cnt_d = EN_LD;
        S_CONFIG:                        cnt_d = CFG_LD;
        S_UNMUTE:                        cnt_d = UNM_LD;
        default:                         cnt_d = 16'd0;
      endcase
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Fault filter: run length of low samples, cleared on any high sample and
  // on every state change.
  always_comb begin
    filt_d = 16'd0;
    if ((state_d == state_q) && active && !amp_fault_n) filt_d = filt_q + 16'd1;
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_comb begin
    amp_en_d     = state_d inside {S_POWER_UP, S_CONFIG, S_WAIT_LOCK, S_UNMUTE, S_RUN, S_SHUTDOWN};
    amp_mute_d   = (state_d != S_RUN);
    i2c_resetb_d = state_d inside {S_CONFIG, S_WAIT_LOCK, S_UNMUTE, S_RUN};
    send_cfg_d   = (state_d == S_CONFIG) && (cnt_d >= PULSE_THR);
    ready_d      = (state_d == S_RUN);
    fail_d       = (state_d == S_FAILED);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      filt_q       <= 16'd0;
      amp_en_q     <= 1'b0;
      amp_mute_q   <= 1'b1;
      i2c_resetb_q <= 1'b0;
      send_cfg_q   <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filt_q       <= filt_d;
      amp_en_q     <= amp_en_d;
      amp_mute_q   <= amp_mute_d;
      i2c_resetb_q <= i2c_resetb_d;
      send_cfg_q   <= send_cfg_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

`ifdef AMP_SEQ_FAULT_RETRY_EN
  // Cleared while passing through IDLE; bumped on each FAULT -> POWER_UP retry.
  always_comb begin
    retry_d = retry_q;
    if ((state_q == S_IDLE) || (state_d == S_IDLE))            retry_d = 4'd0;
    else if ((state_q == S_FAULT) && (state_d == S_POWER_UP))  retry_d = retry_q + 4'd1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) retry_q <= 4'd0;
    else       retry_q <= retry_d;
  end

  assign retry_cnt = retry_q;
`else
  assign retry_cnt = 4'd0;
`endif

  assign amp_en     = amp_en_q;
  assign amp_mute   = amp_mute_q;
  assign i2c_resetb = i2c_resetb_q;
  assign send_cfg   = send_cfg_q;
  assign ready      = ready_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Testbench for amp_pwr_seq: directed timing scenarios followed by randomized
// stimulus, every cycle compared against a phase/age reference model.
module tb_amp_pwr_seq;

  localparam int EN_DLY     = 8;
  localparam int CFG_PULSE  = 4;
  localparam int CFG_WAIT   = 20;
  localparam int UNMUTE_DLY = 5;
  localparam int FAULT_FILT = 3;
  localparam int MAX_RETRY  = 2;
`ifdef AMP_SEQ_FAULT_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  // {amp_en, amp_mute, i2c_resetb, send_cfg, ready, fail, retry_cnt[3:0]}
  localparam logic [9:0] RST_VEC = 10'b0100000000;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       i2s_lock = 1'b0;
  logic       amp_fault_n = 1'b1;
  logic       amp_en, amp_mute, i2c_resetb, send_cfg, ready, fail;
  logic [3:0] retry_cnt;

  amp_pwr_seq #(
    .EN_DLY(EN_DLY), .CFG_PULSE(CFG_PULSE), .CFG_WAIT(CFG_WAIT),
    .UNMUTE_DLY(UNMUTE_DLY), .FAULT_FILT(FAULT_FILT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .i2s_lock(i2s_lock),
    .amp_fault_n(amp_fault_n), .amp_en(amp_en), .amp_mute(amp_mute),
    .i2c_resetb(i2c_resetb), .send_cfg(send_cfg), .ready(ready),
    .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: the sequence phase plus the number of edges spent in it.
  typedef enum int {P_IDLE, P_PWR, P_CFG, P_LOCKW, P_UNM, P_RUN, P_FLT, P_FAILED, P_SHUT} phase_e;
  phase_e ph = P_IDLE;
  int age = 0;
  int lows = 0;
  int retries = 0;

  function automatic int dur(phase_e p);
    case (p)
      P_PWR, P_FLT, P_SHUT: return EN_DLY;
      P_CFG:                return CFG_WAIT;
      P_UNM:                return UNMUTE_DLY;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [9:0] model_vec();
    logic en, mute, rb, cfg, rdy, fl;
    en   = ph inside {P_PWR, P_CFG, P_LOCKW, P_UNM, P_RUN, P_SHUT};
    mute = (ph != P_RUN);
    rb   = ph inside {P_CFG, P_LOCKW, P_UNM, P_RUN};
    cfg  = (ph == P_CFG) && (age < CFG_PULSE);
    rdy  = (ph == P_RUN);
    fl   = (ph == P_FAILED);
    return {en, mute, rb, cfg, rdy, fl, 4'(retries)};
  endfunction

  function automatic logic [9:0] outs();
    return {amp_en, amp_mute, i2c_resetb, send_cfg, ready, fail, retry_cnt};
  endfunction

  task automatic model_reset();
    ph = P_IDLE; age = 0; lows = 0; retries = 0;
  endtask

  task automatic model_step();
    phase_e nx;
    bit act, expired;
    int nlows;
    nx      = ph;
    act     = ph inside {P_PWR, P_CFG, P_LOCKW, P_UNM, P_RUN};
    expired = (dur(ph) != 0) && (age + 1 >= dur(ph));
    nlows   = (act && !amp_fault_n) ? lows + 1 : 0;
    if (act && nlows >= FAULT_FILT) nx = P_FLT;
    else if (act && !start)         nx = P_SHUT;
    else begin
      case (ph)
        P_IDLE:   if (start) nx = P_PWR;
        P_PWR:    if (expired) nx = P_CFG;
        P_CFG:    if (expired) nx = P_LOCKW;
        P_LOCKW:  if (i2s_lock) nx = P_UNM;
        P_UNM:    if (!i2s_lock) nx = P_LOCKW; else if (expired) nx = P_RUN;
        P_RUN:    if (!i2s_lock) nx = P_LOCKW;
        P_FLT: if (expired) begin
          if (RETRY_ON && retries < MAX_RETRY) begin nx = P_PWR; retries++; end
          else nx = P_FAILED;
        end
        P_FAILED: if (!start) nx = P_IDLE;
        P_SHUT:   if (expired) nx = P_IDLE;
        default:  nx = P_IDLE;
      endcase
    end
    if (nx == P_IDLE || ph == P_IDLE) retries = 0;
    age  = (nx != ph) ? 0 : age + 1;
    lows = (nx != ph) ? 0 : nlows;
    ph   = nx;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    edge_n++;
    model_step();
    #1;
    chk("model", 32'(outs()), 32'(model_vec()));
  endtask

  task automatic run_to(int e);
    while (edge_n < e) step();
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    reset = 1'b1; start = 1'b0; i2s_lock = 1'b0; amp_fault_n = 1'b1;
    model_reset();
    #1 chk("reset_vals", 32'(outs()), 32'(RST_VEC));
    @(negedge clk_in);
    reset = 1'b0;
    edge_n = 0;
  endtask

  int low_left;

  initial begin
    // Power-up with lock already present.
    apply_reset();
    i2s_lock = 1'b1;
    run_to(9);  start = 1'b1;
    run_to(10); chk("amp_en_at_10", 32'(amp_en), 1);
    run_to(17); chk("cfg_low_17", 32'(send_cfg), 0); chk("resetb_low_17", 32'(i2c_resetb), 0);
    run_to(18); chk("cfg_high_18", 32'(send_cfg), 1); chk("resetb_high_18", 32'(i2c_resetb), 1);
    run_to(21); chk("cfg_high_21", 32'(send_cfg), 1);
    run_to(22); chk("cfg_low_22", 32'(send_cfg), 0);
    run_to(43); chk("ready_low_43", 32'(ready), 0);
    run_to(44); chk("ready_44", 32'(ready), 1); chk("unmute_44", 32'(amp_mute), 0);
    // Lock loss in RUN, restored just after edge 60.
    run_to(49); i2s_lock = 1'b0;
    run_to(50); chk("ready_drop_50", 32'(ready), 0); chk("mute_50", 32'(amp_mute), 1);
    run_to(60); i2s_lock = 1'b1;
    run_to(65); chk("ready_low_65", 32'(ready), 0);
    run_to(66); chk("ready_66", 32'(ready), 1);

    // Shutdown, with start re-raised while it is running.
    apply_reset();
    i2s_lock = 1'b1;
    run_to(9);  start = 1'b1;
    run_to(49); start = 1'b0;
    run_to(50); chk("shut_en_50", 32'(amp_en), 1); chk("shut_mute_50", 32'(amp_mute), 1);
    chk("shut_resetb_50", 32'(i2c_resetb), 0);
    run_to(54); start = 1'b1;
    run_to(57); chk("shut_en_57", 32'(amp_en), 1);
    run_to(58); chk("idle_en_58", 32'(amp_en), 0);
    run_to(59); chk("repower_59", 32'(amp_en), 1);

    // Sustained fault from edge 30.
    apply_reset();
    i2s_lock = 1'b1;
    run_to(9);  start = 1'b1;
    run_to(29); amp_fault_n = 1'b0;
    run_to(31); chk("pre_fault_31", 32'(amp_en), 1);
    run_to(32); chk("fault_en_32", 32'(amp_en), 0); chk("fault_rb_32", 32'(i2c_resetb), 0);
`ifdef AMP_SEQ_FAULT_RETRY_EN
    run_to(40); chk("retry1_cnt", 32'(retry_cnt), 1); chk("retry1_en", 32'(amp_en), 1);
    run_to(61); chk("fail_low_61", 32'(fail), 0);
    run_to(62); chk("fail_62", 32'(fail), 1); chk("retry_cnt_62", 32'(retry_cnt), 2);
`else
    run_to(39); chk("fail_low_39", 32'(fail), 0);
    run_to(40); chk("fail_40", 32'(fail), 1); chk("retry_cnt_0", 32'(retry_cnt), 0);
`endif
    amp_fault_n = 1'b1; start = 1'b0;
    step(); chk("failed_to_idle", 32'(fail), 0); chk("idle_retry", 32'(retry_cnt), 0);

    // Two-cycle fault glitches must be filtered out.
    apply_reset();
    i2s_lock = 1'b1;
    run_to(9);  start = 1'b1;
    while (edge_n < 60) begin
      amp_fault_n = ((edge_n + 1) % 3 == 0);
      step();
    end
    amp_fault_n = 1'b1;
    chk("glitch_ready", 32'(ready), 1); chk("glitch_en", 32'(amp_en), 1);

    // Asynchronous reset while CONFIG is pulsing send_cfg.
    apply_reset();
    run_to(9);  start = 1'b1;
    run_to(19); chk("cfg_before_rst", 32'(send_cfg), 1);
    #3 reset = 1'b1;
    model_reset();
    #1 chk("async_rst_vals", 32'(outs()), 32'(RST_VEC));
    @(negedge clk_in); reset = 1'b0; start = 1'b0; edge_n = 0;

    // Randomized traffic against the model.
    start = 1'b1; i2s_lock = 1'b1; low_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) start = ~start;
      if ($urandom_range(0, 24) == 0) i2s_lock = ~i2s_lock;
      if (low_left > 0) begin
        amp_fault_n = 1'b0; low_left--;
      end else begin
        amp_fault_n = 1'b1;
        if ($urandom_range(0, 29) == 0) low_left = int'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 399) == 0) begin
        #3 reset = 1'b1;
        model_reset();
        #1 chk("rand_rst_vals", 32'(outs()), 32'(RST_VEC));
        #2 reset = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
